// File: rtl/timer_pkg.sv
// Shared constants and helpers for the multi-channel compare/interrupt unit.
package timer_pkg;

  localparam int CNT_W_DEFAULT = 64;

  localparam logic ONESHOT  = 1'b0;
  localparam logic PERIODIC = 1'b1;

  // Channel-index width: a single-channel build still needs a one-bit index.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_compare_interrupt_compare_channel.sv
// One compare channel: match detection, one-shot/periodic re-arm,
// sticky pending status and overrun tracking.
module compare_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [CNT_W-1:0] cnt_val,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_cmp,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_periodic,
  input  logic             int_clr,
  output logic             status,
  output logic             overrun
);

  logic [CNT_W-1:0] cmp;
  logic [CNT_W-1:0] period;
  logic             periodic;
  logic             armed;
  logic             hit_q;
  logic             hit;
  logic             evt;

  assign hit = armed & (cnt_val == cmp);
  assign evt = hit & ~hit_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cmp      <= '0;
      period   <= '0;
      periodic <= ONESHOT;
      armed    <= 1'b0;
      hit_q    <= 1'b0;
      status   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      hit_q <= hit;
      // A config write overrides the re-arm side of a coincident event.
      if (cfg_we) begin
        cmp      <= cfg_cmp;
        period   <= cfg_period;
        periodic <= cfg_periodic;
        armed    <= 1'b1;
        hit_q    <= 1'b0;
      end else if (evt) begin
        if (periodic == PERIODIC && period != '0)
          cmp <= cmp + period;
        else
          armed <= 1'b0;
      end

      // Setting beats clearing; overrun only when the old event is still unacknowledged.
      if (evt) begin
        status <= 1'b1;
        if (status && !int_clr)
          overrun <= 1'b1;
      end else if (int_clr) begin
        status  <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_compare_interrupt.sv
// Multi-channel compare/interrupt unit: per-channel config decode, output
// masking and lowest-index pending channel selection.
module multi_compare_interrupt
  import timer_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = CNT_W_DEFAULT,
  localparam int CH_IDX_W = ch_idx_w(NUM_CH)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [CNT_W-1:0]    cnt_val,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_cmp,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic                cfg_periodic,
  input  logic [NUM_CH-1:0]   int_en,
  input  logic [NUM_CH-1:0]   int_clr,
  output logic [NUM_CH-1:0]   int_status,
  output logic [NUM_CH-1:0]   int_overrun,
  output logic [NUM_CH-1:0]   tim_int_vec,
  output logic                tim_int,
  output logic [CH_IDX_W-1:0] int_id,
  output logic                int_id_vld
);

  logic [NUM_CH-1:0] ch_we;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_we[g] = cfg_we && (cfg_ch == CH_IDX_W'(g));

    compare_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .cnt_val      (cnt_val),
      .cfg_we       (ch_we[g]),
      .cfg_cmp      (cfg_cmp),
      .cfg_period   (cfg_period),
      .cfg_periodic (cfg_periodic),
      .int_clr      (int_clr[g]),
      .status       (int_status[g]),
      .overrun      (int_overrun[g])
    );
  end

  assign tim_int_vec = int_status & int_en;
  assign tim_int     = |tim_int_vec;
  assign int_id_vld  = tim_int;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    int_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (tim_int_vec[i])
        int_id = CH_IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_multi_compare_interrupt.sv
// Directed scenarios plus randomized traffic for multi_compare_interrupt,
// checked against a behavioural per-channel model.
module tb_multi_compare_interrupt;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 64;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [CNT_W-1:0]  cnt_val;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_cmp;
  logic [CNT_W-1:0]  cfg_period;
  logic              cfg_periodic;
  logic [NUM_CH-1:0] int_en;
  logic [NUM_CH-1:0] int_clr;
  logic [NUM_CH-1:0] int_status;
  logic [NUM_CH-1:0] int_overrun;
  logic [NUM_CH-1:0] tim_int_vec;
  logic              tim_int;
  logic [1:0]        int_id;
  logic              int_id_vld;

  multi_compare_interrupt #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .cnt_val      (cnt_val),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_cmp      (cfg_cmp),
    .cfg_period   (cfg_period),
    .cfg_periodic (cfg_periodic),
    .int_en       (int_en),
    .int_clr      (int_clr),
    .int_status   (int_status),
    .int_overrun  (int_overrun),
    .tim_int_vec  (tim_int_vec),
    .tim_int      (tim_int),
    .int_id       (int_id),
    .int_id_vld   (int_id_vld)
  );

  always #50 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  string phase = "reset";

  // Behavioural model: what each channel is waiting for and what it has latched.
  logic [CNT_W-1:0]  m_cmp    [NUM_CH];
  logic [CNT_W-1:0]  m_per    [NUM_CH];
  logic              m_perd   [NUM_CH];
  logic              m_armed  [NUM_CH];
  logic              m_seen   [NUM_CH];
  logic [NUM_CH-1:0] m_status;
  logic [NUM_CH-1:0] m_ovr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  // Apply one clock edge to the model using the inputs as they were at the edge.
  task automatic model_edge();
    logic match, ev;
    if (sys_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cmp[i] = '0; m_per[i] = '0; m_perd[i] = 1'b0;
        m_armed[i] = 1'b0; m_seen[i] = 1'b0;
      end
      m_status = '0;
      m_ovr    = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        match = m_armed[i] && (cnt_val == m_cmp[i]);
        ev    = match && !m_seen[i];
        if (cfg_we && cfg_ch == 2'(i)) begin
          m_cmp[i] = cfg_cmp; m_per[i] = cfg_period; m_perd[i] = cfg_periodic;
          m_armed[i] = 1'b1; m_seen[i] = 1'b0;
        end else begin
          m_seen[i] = match;
          if (ev) begin
            if (m_perd[i] && m_per[i] != 0) m_cmp[i] = m_cmp[i] + m_per[i];
            else                             m_armed[i] = 1'b0;
          end
        end
        if (ev) begin
          if (m_status[i] && !int_clr[i]) m_ovr[i] = 1'b1;
          m_status[i] = 1'b1;
        end else if (int_clr[i]) begin
          m_status[i] = 1'b0;
          m_ovr[i]    = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [NUM_CH-1:0] vec;
    logic [1:0] id;
    vec = m_status & int_en;
    id = 2'd0;
    for (int i = 0; i < NUM_CH; i++)
      if (vec[i] && (vec & ((4'd1 << i) - 4'd1)) == 0) id = 2'(i);
    chk("status",  64'(int_status),  64'(m_status));
    chk("overrun", 64'(int_overrun), 64'(m_ovr));
    chk("vec",     64'(tim_int_vec), 64'(vec));
    chk("tim_int", 64'(tim_int),     64'(vec != 0));
    chk("int_id",  64'(int_id),      64'(id));
    chk("id_vld",  64'(int_id_vld),  64'(vec != 0));
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    #1;
    check_outputs();
    cfg_we  = 1'b0;
    int_clr = '0;
    sys_rst = 1'b0;
  endtask

  task automatic cfg(input int ch, input logic [63:0] c, input logic [63:0] p, input logic perd);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_cmp = c; cfg_period = p; cfg_periodic = perd;
  endtask

  int rises;
  logic prev_s2;

  initial begin
    sys_rst = 1'b1; cnt_val = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_cmp = '0;
    cfg_period = '0; cfg_periodic = 1'b0; int_en = '0; int_clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cmp[i] = 'x; m_per[i] = 'x; m_perd[i] = 1'bx; m_armed[i] = 1'bx; m_seen[i] = 1'bx;
    end
    m_status = 'x; m_ovr = 'x;
    sys_rst = 1'b1;
    tick();
    chk("rst_status", 64'(int_status), 64'd0);
    chk("rst_tim_int", 64'(tim_int), 64'd0);

    // One-shot on ch0 at cnt==5
    phase = "oneshot";
    int_en = 4'b0001;
    cfg(0, 64'd5, 64'd0, 1'b0);
    tick();
    for (int c = 0; c <= 8; c++) begin
      cnt_val = 64'(c);
      tick();
      if (c == 4) chk("pre_match_int", 64'(tim_int), 64'd0);
      if (c == 5) begin
        chk("match_status0", 64'(int_status[0]), 64'd1);
        chk("match_id", 64'(int_id), 64'd0);
      end
      if (c == 8) chk("sticky_int", 64'(tim_int), 64'd1);
    end

    // Clear, then counter returns to 5: channel is unarmed
    phase = "clear";
    int_clr = 4'b0001;
    tick();
    chk("cleared_int", 64'(tim_int), 64'd0);
    for (int c = 0; c <= 6; c++) begin cnt_val = 64'(c); tick(); end
    chk("no_refire", 64'(int_status[0]), 64'd0);

    // Masked pending channel, then unmasked combinationally
    phase = "mask";
    cfg(1, 64'd5, 64'd0, 1'b0);
    tick();
    cnt_val = 64'd4; tick();
    cnt_val = 64'd5; tick();
    chk("masked_status1", 64'(int_status[1]), 64'd1);
    chk("masked_int", 64'(tim_int), 64'd0);
    int_en = 4'b0011;
    #1;
    chk("unmask_int", 64'(tim_int), 64'd1);
    chk("unmask_id", 64'(int_id), 64'd1);
    int_clr = 4'b0010;
    tick();

    // Periodic with acknowledgement after every event
    phase = "periodic";
    int_en = 4'b0100;
    cfg(2, 64'd10, 64'd10, 1'b1);
    tick();
    rises = 0; prev_s2 = 1'b0;
    for (int c = 0; c <= 35; c++) begin
      cnt_val = 64'(c);
      int_clr = {1'b0, m_status[2], 2'b00};
      tick();
      if (int_status[2] && !prev_s2) rises++;
      prev_s2 = int_status[2];
    end
    chk("periodic_events", 64'(rises), 64'd3);
    chk("periodic_no_ovr", 64'(int_overrun[2]), 64'd0);
    int_clr = 4'b0100;
    tick();

    // Same without acknowledgement: second event overruns
    phase = "overrun";
    cfg(2, 64'd10, 64'd10, 1'b1);
    tick();
    for (int c = 0; c <= 21; c++) begin cnt_val = 64'(c); tick(); end
    chk("overrun2", 64'(int_overrun[2]), 64'd1);
    int_clr = 4'b0100;
    tick();
    chk("overrun_clr", 64'(int_overrun[2]), 64'd0);

    // Compare wraps modulo 2^64
    phase = "wrap";
    cfg(2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1);
    tick();
    cnt_val = 64'hFFFF_FFFF_FFFF_FFFD; tick();
    int_clr = 4'b0100; cnt_val = 64'hFFFF_FFFF_FFFF_FFFE; tick();
    chk("wrap_cleared", 64'(int_status[2]), 64'd0);
    cnt_val = 64'd2; tick();
    chk("wrap_fire", 64'(int_status[2]), 64'd1);
    int_clr = 4'b0100; tick();

    // Clear coinciding with an event, and priority between ch1 and ch3
    phase = "simul";
    int_en = 4'b1010;
    cfg(3, 64'd7, 64'd0, 1'b0); tick();
    cfg(1, 64'd7, 64'd0, 1'b0); tick();
    cnt_val = 64'd6; tick();
    cnt_val = 64'd7; int_clr = 4'b1000; tick();
    chk("set_wins3", 64'(int_status[3]), 64'd1);
    chk("prio_id1", 64'(int_id), 64'd1);
    int_clr = 4'b0010; tick();
    chk("prio_id3", 64'(int_id), 64'd3);

    // Stalled counter fires once, then reset discards everything
    phase = "stall";
    int_clr = 4'b1111; tick();
    int_en = 4'b0001;
    cfg(0, 64'd9, 64'd0, 1'b1);
    cnt_val = 64'd8; tick();
    cnt_val = 64'd9;
    for (int k = 0; k < 3; k++) tick();
    chk("stall_once", 64'(int_overrun[0]), 64'd0);
    chk("stall_status", 64'(int_status[0]), 64'd1);
    sys_rst = 1'b1; tick();
    chk("reset_status", 64'(int_status), 64'd0);
    chk("reset_int", 64'(tim_int), 64'd0);
    cnt_val = 64'd0; int_en = 4'b1111; tick(); tick();
    chk("post_reset_quiet", 64'(int_status), 64'd0);

    // Randomized traffic over a small counter range to force frequent matches
    phase = "random";
    for (int n = 0; n < 400; n++) begin
      cnt_val = 64'($urandom_range(0, 15));
      int_en  = 4'($urandom);
      int_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      if ($urandom_range(0, 5) == 0)
        cfg($urandom_range(0, 3), 64'($urandom_range(0, 15)),
            64'($urandom_range(0, 5)), 1'($urandom));
      if ($urandom_range(0, 63) == 0) sys_rst = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
